// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the byte-serial program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package prog_loader_pkg;

    localparam int INSTR_W = 9;   // machine code word width
    localparam int COUNT_W = 12;  // width of the frame word count field
    localparam int BYTE_W  = 8;   // frame byte width

    typedef enum logic [3:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        INS_LO,
        INS_HI,
        CHK,
        START,
        RUN,
        ERR
    } ldr_state_t;

    // States in which the loader is consuming frame bytes.
    function automatic logic in_frame(input ldr_state_t s);
        return (s == CNT_LO) || (s == CNT_HI) || (s == INS_LO) ||
               (s == INS_HI) || (s == CHK);
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running 8-bit XOR of accepted frame bytes; ports: clk, rst, clr, en, din -> sum.
// Latency: sum reflects a byte one cycle after en; clr wins over en.
// Backpressure: none; the caller decides which bytes are folded in.
module loader_checksum
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] sum
);

    logic [BYTE_W-1:0] sum_d;
    logic [BYTE_W-1:0] sum_q;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (en) begin
            sum_d = sum_q ^ din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a checksummed byte frame into instruction memory, then starts the core and waits for done.
// Latency: write strobe 1 cycle after INS_HI accept; core_start 1 cycle after a matching CHK accept.
// Backpressure: in_ready high only while a frame is being parsed; the source holds its byte otherwise.
// Ports: clk/reset; load_req; in_data/in_valid/in_ready byte stream; im_wr_* memory write port;
//        core_reset/core_start/core_done core control; busy/error/loaded_count status.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int D         = 12,
    parameter int MAX_WORDS = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_req,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               im_wr_en,
    output logic [D-1:0]       im_wr_addr,
    output logic [INSTR_W-1:0] im_wr_data,
    output logic               core_reset,
    output logic               core_start,
    input  logic               core_done,
    output logic               busy,
    output logic               error,
    output logic [D-1:0]       loaded_count
);

    ldr_state_t         state_d, state_q;
    logic               in_ready_d, in_ready_q;
    logic               im_wr_en_d, im_wr_en_q;
    logic [D-1:0]       im_wr_addr_d, im_wr_addr_q;
    logic [INSTR_W-1:0] im_wr_data_d, im_wr_data_q;
    logic               core_reset_d, core_reset_q;
    logic               core_start_d, core_start_q;
    logic               busy_d, busy_q;
    logic               error_d, error_q;
    logic [D-1:0]       loaded_count_d, loaded_count_q;
    logic [D-1:0]       index_d, index_q;
    logic [COUNT_W-1:0] count_d, count_q;
    logic [BYTE_W-1:0]  cnt_lo_d, cnt_lo_q;
    logic [BYTE_W-1:0]  ins_lo_d, ins_lo_q;

    logic               accept;
    logic               start_load;
    logic [COUNT_W-1:0] cnt_word;
    logic [D-1:0]       index_inc;
    logic [BYTE_W-1:0]  chk_sum;

    assign accept     = in_valid && in_ready_q;
    // load_req is only honoured outside an active frame.
    assign start_load = load_req && ((state_q == IDLE) || (state_q == RUN) || (state_q == ERR));
    assign cnt_word   = {in_data[3:0], cnt_lo_q};
    assign index_inc  = index_q + D'(1);

    // The CHK byte itself is compared, never folded in.
    loader_checksum u_checksum (
        .clk (clk),
        .rst (reset),
        .clr (start_load),
        .en  (accept && (state_q != CHK)),
        .din (in_data),
        .sum (chk_sum)
    );

    always_comb begin
        state_d        = state_q;
        im_wr_en_d     = 1'b0;
        im_wr_addr_d   = im_wr_addr_q;
        im_wr_data_d   = im_wr_data_q;
        core_reset_d   = core_reset_q;
        core_start_d   = 1'b0;
        busy_d         = busy_q;
        error_d        = error_q;
        loaded_count_d = loaded_count_q;
        index_d        = index_q;
        count_d        = count_q;
        cnt_lo_d       = cnt_lo_q;
        ins_lo_d       = ins_lo_q;

        if (start_load) begin
            // Covers IDLE, RUN and ERR; load_req beats core_done in RUN.
            state_d        = CNT_LO;
            error_d        = 1'b0;
            index_d        = '0;
            loaded_count_d = '0;
            core_reset_d   = 1'b1;
            busy_d         = 1'b1;
        end else begin
            case (state_q)
                CNT_LO: if (accept) begin
                    cnt_lo_d = in_data;
                    state_d  = CNT_HI;
                end
                CNT_HI: if (accept) begin
                    count_d = cnt_word;
                    if ((in_data[7:4] != 4'h0) || (int'(cnt_word) > MAX_WORDS)) begin
                        state_d = ERR;
                    end else if (cnt_word == '0) begin
                        state_d = CHK;
                    end else begin
                        state_d = INS_LO;
                    end
                end
                INS_LO: if (accept) begin
                    ins_lo_d = in_data;
                    state_d  = INS_HI;
                end
                INS_HI: if (accept) begin
                    if (in_data[7:1] != 7'h00) begin
                        state_d = ERR;
                    end else begin
                        im_wr_en_d     = 1'b1;
                        im_wr_addr_d   = index_q;
                        im_wr_data_d   = {in_data[0], ins_lo_q};
                        index_d        = index_inc;
                        loaded_count_d = loaded_count_q + D'(1);
                        state_d        = (int'(index_inc) == int'(count_q)) ? CHK : INS_LO;
                    end
                end
                CHK: if (accept) begin
                    state_d = (in_data == chk_sum) ? START : ERR;
                end
                START:   state_d = RUN;
                RUN:     if (core_done) state_d = IDLE;
                IDLE:    state_d = IDLE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered against the state being entered.
        if (state_d == ERR) begin
            error_d      = 1'b1;
            core_reset_d = 1'b1;
            busy_d       = 1'b0;
        end
        if (state_d == START) begin
            core_start_d = 1'b1;
            core_reset_d = 1'b0;
            busy_d       = 1'b0;
        end
        in_ready_d = in_frame(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b0;
            im_wr_en_q     <= 1'b0;
            im_wr_addr_q   <= '0;
            im_wr_data_q   <= '0;
            core_reset_q   <= 1'b1;
            core_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
            loaded_count_q <= '0;
            index_q        <= '0;
            count_q        <= '0;
            cnt_lo_q       <= '0;
            ins_lo_q       <= '0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            im_wr_en_q     <= im_wr_en_d;
            im_wr_addr_q   <= im_wr_addr_d;
            im_wr_data_q   <= im_wr_data_d;
            core_reset_q   <= core_reset_d;
            core_start_q   <= core_start_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
            loaded_count_q <= loaded_count_d;
            index_q        <= index_d;
            count_q        <= count_d;
            cnt_lo_q       <= cnt_lo_d;
            ins_lo_q       <= ins_lo_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign im_wr_en     = im_wr_en_q;
    assign im_wr_addr   = im_wr_addr_q;
    assign im_wr_data   = im_wr_data_q;
    assign core_reset   = core_reset_q;
    assign core_start   = core_start_q;
    assign busy         = busy_q;
    assign error        = error_q;
    assign loaded_count = loaded_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are parsed by a queue-based model and compared with DUT writes/status.
// Latency: checks write strobe and core_start one cycle after the relevant byte accept.
// Backpressure: drives in_valid continuously, toggled or randomly; holds bytes until accepted.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int D         = 12;
    localparam int MAX_WORDS = 128;

    typedef logic [7:0] byte_q_t[$];

    logic               clk = 1'b0;
    logic               reset;
    logic               load_req;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               im_wr_en;
    logic [D-1:0]       im_wr_addr;
    logic [INSTR_W-1:0] im_wr_data;
    logic               core_reset;
    logic               core_start;
    logic               core_done;
    logic               busy;
    logic               error;
    logic [D-1:0]       loaded_count;

    prog_loader #(.D(D), .MAX_WORDS(MAX_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .im_wr_en     (im_wr_en),
        .im_wr_addr   (im_wr_addr),
        .im_wr_data   (im_wr_data),
        .core_reset   (core_reset),
        .core_start   (core_start),
        .core_done    (core_done),
        .busy         (busy),
        .error        (error),
        .loaded_count (loaded_count)
    );

    always #5 clk = ~clk;

    int                   n_cmp = 0;
    int                   n_bad = 0;
    byte_q_t              frm;
    logic [INSTR_W-1:0]   m_words[$];
    int                   m_nsend;
    logic                 m_err;
    logic [D+INSTR_W-1:0] wr_log[$];
    int                   start_cnt = 0;
    logic [INSTR_W-1:0]   tb_mem[0:MAX_WORDS-1];
    int                   wb_mid;

    // Instruction memory stand-in plus event log.
    always @(negedge clk) begin
        if (im_wr_en) begin
            wr_log.push_back({im_wr_addr, im_wr_data});
            if (int'(im_wr_addr) < MAX_WORDS) tb_mem[im_wr_addr[6:0]] = im_wr_data;
        end
        if (core_start) start_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string p);
        check_eq({p, "_rdy"},    in_ready,     0);
        check_eq({p, "_wren"},   im_wr_en,     0);
        check_eq({p, "_waddr"},  im_wr_addr,   0);
        check_eq({p, "_wdata"},  im_wr_data,   0);
        check_eq({p, "_creset"}, core_reset,   1);
        check_eq({p, "_cstart"}, core_start,   0);
        check_eq({p, "_busy"},   busy,         0);
        check_eq({p, "_err"},    error,        0);
        check_eq({p, "_lcnt"},   loaded_count, 0);
    endtask

    // Frame interpretation straight from the frame format rules.
    task automatic model_frame(input byte_q_t b);
        int         cnt;
        logic [7:0] x;
        m_words.delete();
        m_err = 1'b0;
        cnt = {b[1][3:0], b[0]};
        if (b[1][7:4] != 4'h0 || cnt > MAX_WORDS) begin
            m_err = 1'b1; m_nsend = 2; return;
        end
        for (int i = 0; i < cnt; i++) begin
            if (b[3+2*i][7:1] != 7'h00) begin
                m_err = 1'b1; m_nsend = 4 + 2*i; return;
            end
            m_words.push_back({b[3+2*i][0], b[2+2*i]});
        end
        x = 8'h00;
        for (int k = 0; k < 2 + 2*cnt; k++) x = x ^ b[k];
        m_nsend = 3 + 2*cnt;
        m_err   = (b[2+2*cnt] != x);
    endtask

    // kind: 0-3 good, 4 bad CNT_HI nibble, 5 count > MAX, 6 bad INS_HI, 7 bad CHK.
    task automatic build_frame(input int cnt, input int kind);
        logic [11:0] c12;
        logic [3:0]  nib;
        logic [7:0]  lo, hi, x;
        int          bad;
        c12 = 12'(cnt);
        nib = (kind == 4) ? 4'($urandom_range(1, 15)) : 4'h0;
        bad = (cnt > 0) ? int'($urandom_range(0, cnt - 1)) : 0;
        frm.delete();
        frm.push_back(c12[7:0]);
        frm.push_back({nib, c12[11:8]});
        if (kind != 5) begin
            for (int i = 0; i < cnt; i++) begin
                lo = 8'($urandom);
                hi = {7'h00, 1'($urandom)};
                if (kind == 6 && i == bad) hi[7:1] = 7'($urandom_range(1, 127));
                frm.push_back(lo);
                frm.push_back(hi);
            end
        end
        x = 8'h00;
        foreach (frm[k]) x = x ^ frm[k];
        if (kind == 7) x = x ^ 8'($urandom_range(1, 255));
        frm.push_back(x);
    endtask

    // mode: 0 always valid, 1 toggle valid, 2 random valid plus stray load_req.
    task automatic send_bytes(input int nsend, input int mode, input logic exp_start);
        int   idx, budget, cyc;
        logic v, rdy_now;
        idx = 0; budget = 0; cyc = 0;
        while (idx < nsend && budget < 8*nsend + 32) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom);
            endcase
            in_valid = v;
            in_data  = frm[idx];
            if (mode == 2) load_req = ($urandom_range(0, 7) == 0);
            rdy_now = in_ready;
            if (mode == 1 && !v) check_eq("rdy_hold", in_ready, 1);
            @(negedge clk);
            budget++; cyc++;
            if (v && rdy_now) begin
                if (idx >= 3 && (idx - 3) % 2 == 0 && (idx - 3) / 2 < m_words.size()) begin
                    check_eq("wr_strobe", im_wr_en, 1);
                    check_eq("wr_addr", im_wr_addr, (idx - 3) / 2);
                    check_eq("wr_data", im_wr_data, m_words[(idx - 3) / 2]);
                end
                if (idx == nsend - 1) check_eq("start_lat", core_start, exp_start);
                idx++;
            end
        end
        in_valid = 1'b0;
        load_req = 1'b0;
        if (idx < nsend) check_eq("send_timeout", idx, nsend);
    endtask

    task automatic run_frame(input int mode, input logic done_too);
        int wb, sb;
        model_frame(frm);
        wb = wr_log.size();
        sb = start_cnt;
        load_req  = 1'b1;
        core_done = done_too;
        @(negedge clk);
        load_req  = 1'b0;
        core_done = 1'b0;
        check_eq("ld_rdy", in_ready, 1);
        check_eq("ld_creset", core_reset, 1);
        check_eq("ld_busy", busy, 1);
        check_eq("ld_err", error, 0);
        check_eq("ld_lcnt", loaded_count, 0);
        send_bytes(m_nsend, mode, !m_err);
        repeat (3) @(negedge clk);
        check_eq("n_writes", wr_log.size() - wb, m_words.size());
        for (int i = 0; i < m_words.size() && wb + i < wr_log.size(); i++)
            check_eq("wr_entry", wr_log[wb+i], {D'(i), m_words[i]});
        check_eq("n_starts", start_cnt - sb, m_err ? 0 : 1);
        check_eq("err_end", error, m_err);
        check_eq("lcnt_end", loaded_count, m_words.size());
        check_eq("creset_end", core_reset, m_err);
        check_eq("busy_end", busy, 0);
        check_eq("rdy_end", in_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00; core_done = 1'b0;
        #1;
        check_reset_vals("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");

        // Three-word directed frame.
        frm = '{8'h03, 8'h00, 8'h45, 8'h01, 8'h12, 8'h00, 8'hFF, 8'h01, 8'hAB};
        run_frame(0, 1'b0);
        check_eq("t1_w0", tb_mem[0], 9'h145);
        check_eq("t1_w1", tb_mem[1], 9'h012);
        check_eq("t1_w2", tb_mem[2], 9'h1FF);
        check_eq("t1_lcnt", loaded_count, 3);

        // Empty program.
        frm = '{8'h00, 8'h00, 8'h00};
        run_frame(0, 1'b0);

        // Count 129 is rejected; core_done in ERR changes nothing.
        frm = '{8'h81, 8'h00};
        run_frame(0, 1'b0);
        check_eq("t3_err", error, 1);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        check_eq("err_done_err", error, 1);
        check_eq("err_done_creset", core_reset, 1);

        // Two words, checksum off by one.
        build_frame(2, 0);
        frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
        run_frame(0, 1'b0);

        // One word with in_valid toggling.
        build_frame(1, 0);
        run_frame(1, 1'b0);

        // Reset between INS_LO and INS_HI of word 1.
        build_frame(2, 0);
        model_frame(frm);
        wb_mid   = wr_log.size();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        send_bytes(5, 0, 1'b0);
        #2 reset = 1'b1;
        #1 check_reset_vals("mid_rst");
        check_eq("mid_nwr", wr_log.size() - wb_mid, 1);
        check_eq("mid_w0", tb_mem[0], m_words[0]);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        build_frame(3, 0);
        run_frame(0, 1'b0);

        // Largest legal frame.
        build_frame(MAX_WORDS, 0);
        run_frame(0, 1'b0);
        check_eq("max_last_addr", wr_log[wr_log.size()-1][D+INSTR_W-1:INSTR_W], MAX_WORDS - 1);

        // RUN: core_done alone returns to IDLE with the core released.
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check_eq("done_creset", core_reset, 0);
        check_eq("done_busy", busy, 0);
        check_eq("done_rdy", in_ready, 0);
        check_eq("done_cstart", core_start, 0);
        build_frame(2, 0);
        run_frame(0, 1'b0);
        // RUN: load_req together with core_done restarts a load.
        build_frame(3, 0);
        run_frame(2, 1'b1);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            int kind, cnt;
            kind = int'($urandom_range(0, 7));
            if (kind == 5) cnt = int'($urandom_range(MAX_WORDS + 1, 4095));
            else           cnt = int'($urandom_range((kind == 6) ? 1 : 0, 6));
            build_frame(cnt, kind);
            run_frame(int'($urandom_range(0, 2)), 1'b0);
            if (!m_err && $urandom_range(0, 1) == 1) begin
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
                check_eq("rnd_done_creset", core_reset, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-serial program loader that writes 9-bit machine code into the instruction memory, the write side of the memory the core fetches from.
- Holds the core in reset while loading, validates a checksummed frame, then pulses the core's start and waits for its done.
- Sits beside the processor top level, between the host/byte source and the instruction-memory write port.

Parameters:
- D, 12, instruction address width (matches the program counter width).
- MAX_WORDS, 128, maximum number of instructions accepted per frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- load_req  input  1  one-cycle pulse requesting a new load.
- in_data  input  8  frame byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- im_wr_en  output  1  instruction memory write strobe.
- im_wr_addr  output  D  instruction memory write address.
- im_wr_data  output  9  machine code word.
- core_reset  output  1  held high to keep the core in reset.
- core_start  output  1  one-cycle start pulse to the core.
- core_done  input  1  core finished execution.
- busy  output  1  frame load in progress.
- error  output  1  last frame rejected.
- loaded_count  output  D  number of words written in the last frame.

Behaviour:
- Reset values: state IDLE, in_ready=0, im_wr_en=0, im_wr_addr=0, im_wr_data=0, core_reset=1, core_start=0, busy=0, error=0, loaded_count=0, checksum=0, index=0.
- A byte is accepted when in_valid && in_ready. in_valid while in_ready=0 is ignored, and the source holds its byte.
- Frame format, in order:
  - CNT_LO byte.
  - CNT_HI byte; count = {CNT_HI[3:0], CNT_LO}.
  - count × (INS_LO, INS_HI) byte pairs; word = {INS_HI[0], INS_LO}.
  - CHK byte, equal to the XOR of every preceding byte in the frame.
- States:
  - IDLE: in_ready=0. On load_req go to CNT_LO; clear error, checksum, index and loaded_count; set core_reset=1 and busy=1.
  - CNT_LO: in_ready=1. On accept, latch the low count byte and go to CNT_HI.
  - CNT_HI: in_ready=1. On accept:
    - CNT_HI[7:4]≠0 or count>MAX_WORDS → ERR.
    - count==0 → CHK.
    - otherwise → INS_LO.
  - INS_LO: in_ready=1. Latch the byte and go to INS_HI.
  - INS_HI: in_ready=1. On accept:
    - INS_HI[7:1]≠0 → ERR, and no write is issued.
    - otherwise, on the next cycle: im_wr_en=1 for exactly one cycle, im_wr_addr=index, im_wr_data=word. index and loaded_count then increment.
    - next state is CHK when the new index == count, else INS_LO.
  - CHK: in_ready=1. On accept:
    - byte==checksum → START.
    - else → ERR.
  - START: one cycle. core_reset=0, core_start=1, busy=0, then go to RUN.
  - RUN: core_reset=0. On core_done go to IDLE with core_reset staying 0. On load_req go to CNT_LO and reassert core_reset.
  - ERR: core_reset=1, error=1, busy=0. Stay until load_req, which goes to CNT_LO.
- Checksum is an 8-bit running XOR, updated on every accepted byte except CHK itself.
- Latency:
  - Write strobe: one cycle after the INS_HI accept.
  - core_start: one cycle after a matching CHK accept.
  - Minimum frame time: 2+2·count+1 accepted bytes plus 1 cycle.
- Boundary conditions:
  - load_req while in CNT_LO..CHK is ignored.
  - count==MAX_WORDS is legal; last address = MAX_WORDS-1.
  - index never wraps because count is bounded by MAX_WORDS.
  - core_done outside RUN is ignored.
  - load_req and core_done in the same cycle in RUN: load_req wins.
  - Reset mid-frame returns all outputs to reset values asynchronously. Memory words already written are left untouched.

Decomposition:
- Package prog_loader_pkg holds:
  - state enum ldr_state_t {IDLE, CNT_LO, CNT_HI, INS_LO, INS_HI, CHK, START, RUN, ERR}.
  - constants INSTR_W=9, COUNT_W=12, BYTE_W=8.
- One sub-module, loader_checksum: 8-bit XOR accumulator with clr and en inputs, async reset, registered output.

Test Plan:
- Frame 03 00 | 45 01 | 12 00 | FF 01 | chk:
  - 3 writes: addr0=0x145, addr1=0x012, addr2=0x1FF.
  - core_start pulses once the cycle after CHK; loaded_count=3, error=0.
- Count 0, frame 00 00 00 → no writes, core_start pulses, loaded_count=0.
- Count 0x081 (129 > MAX_WORDS), bytes 81 00 → ERR after the CNT_HI accept; error=1, core_reset=1, no writes, no core_start.
- Valid 2-word frame with CHK byte off by 0x01 → both words written, then ERR; error=1, core_start never asserted.
- in_valid toggled 1/0 every cycle through a 1-word frame → each byte is accepted exactly once, the single write is correct, and in_ready stays high while waiting.
- Reset asserted between INS_LO and INS_HI of word 1:
  - outputs return to reset values immediately; word 0 stays in memory.
  - a new load_req and full frame then complete normally.
- In RUN, core_done pulse → IDLE with core_reset=0; load_req in the same cycle instead → CNT_LO with core_reset=1.
